id_ex_stage: RTL and testbench

ID/EX pipeline register and operand-forwarding stage of the 5-stage pipeline. It captures decoded instruction fields at the end of ID. It presents forwarded operands to EX; the ALU's B-operand 2:1 mux selects between `ex_op_b` and `ex_imm` using `ex_alu_src`. It also detects load-use hazards and inserts bubbles itself.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/fwd_unit.sv | 35 +++
 rtl/id_ex_stage.sv | 174 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the 5-stage pipeline.
//   fwd_sel_t   : operand source select (register file, EX/MEM, MEM/WB)
//   alu_op_t    : 4-bit ALU operation code
//   REG_ZERO    : hard-wired zero register index, never forwarded
//   ctrl_t      : packed control bits carried through ID/EX
//   CTRL_BUBBLE : control word of an inserted bubble (all zero)
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    typedef logic [3:0] alu_op_t;

    localparam int unsigned REG_ZERO = 0;

    typedef struct packed {
        logic alu_src;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: chooses the source of one EX operand.
//   src           in  : register address the operand was read from
//   mem_rd/_we    in  : EX/MEM write-back candidate
//   wb_rd/_we     in  : MEM/WB write-back candidate
//   sel           out : FWD_MEM, FWD_WB or FWD_REG
// MEM is the younger producer, so it wins over WB. Register 0 never forwards.
module fwd_unit
    import pipe_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] src,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_reg_write,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_reg_write,
    output fwd_sel_t        sel
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_reg_write && (mem_rd != RA_W'(REG_ZERO)) && (mem_rd == src);
    assign wb_hit  = wb_reg_write  && (wb_rd  != RA_W'(REG_ZERO)) && (wb_rd  == src);

    always_comb begin
        sel = FWD_REG;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding and
// load-use hazard detection.
//   clk, rst (sync, active high), stall (hold), flush (insert bubble)
//   id_*       : decoded instruction fields captured at the end of ID
//   mem_*/wb_* : write-back candidates from EX/MEM and MEM/WB
//   ex_*       : registered fields presented to EX; ex_op_a/ex_op_b forwarded
//   load_use_stall : combinational request for IF/ID to hold one cycle
// Configuration macro: ID_EX_FWD_EN
//   defined   : operands forwarded from MEM (priority) or WB; only a load in
//               EX with a dependent in ID causes a bubble.
//   undefined : operands are always the registered register-file data and any
//               in-flight producer (EX, MEM, WB) of id_rs/id_rt causes a bubble.
// Handshake: there is no valid/ready pair here; ex_valid qualifies the EX slot
// and stall freezes every register for as long as it is high.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs_data,
    input  logic [XLEN-1:0] id_rt_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic [RA_W-1:0] id_rd,
    input  logic [3:0]      id_alu_op,
    input  logic            id_alu_src,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_mem_to_reg,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_alu_out,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_op_a,
    output logic [XLEN-1:0] ex_op_b,
    output logic [RA_W-1:0] ex_rd,
    output logic [3:0]      ex_alu_op,
    output logic            ex_alu_src,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_mem_to_reg,
    output logic            load_use_stall
);

    ctrl_t           ctrl_q;
    ctrl_t           id_ctrl;
    alu_op_t         alu_op_q;
    logic [XLEN-1:0] rs_data_q;
    logic [XLEN-1:0] rt_data_q;
    logic            hazard;
    logic            load_bubble;

    assign id_ctrl = '{alu_src:    id_alu_src,
                       reg_write:  id_reg_write,
                       mem_read:   id_mem_read,
                       mem_write:  id_mem_write,
                       mem_to_reg: id_mem_to_reg};

    // True when producer rd is live, nonzero and read by the instruction in ID.
    function automatic logic id_depends(input logic [RA_W-1:0] rd, input logic we);
        return we && (rd != RA_W'(REG_ZERO)) && id_valid && (rd == id_rs || rd == id_rt);
    endfunction

    // A flush already replaces the slot with a bubble, so the hazard is moot.
    assign load_use_stall = hazard && !flush;
    // Under stall the hazard is not acted on; it is re-evaluated after release.
    assign load_bubble    = load_use_stall && !stall;

`ifdef ID_EX_FWD_EN
    logic [RA_W-1:0] ex_rs_q;
    logic [RA_W-1:0] ex_rt_q;
    fwd_sel_t        sel_a;
    fwd_sel_t        sel_b;

    // Only a load cannot be forwarded in time: its data exists after MEM.
    assign hazard = id_depends(ex_rd, ex_valid && ctrl_q.mem_read);

    fwd_unit #(.RA_W(RA_W)) u_fwd_rs (
        .src(ex_rs_q), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .sel(sel_a)
    );

    fwd_unit #(.RA_W(RA_W)) u_fwd_rt (
        .src(ex_rt_q), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .sel(sel_b)
    );

    always_comb begin
        ex_op_a = rs_data_q;
        case (sel_a)
            FWD_MEM: ex_op_a = mem_alu_out;
            FWD_WB:  ex_op_a = wb_data;
            default: ex_op_a = rs_data_q;
        endcase
    end

    always_comb begin
        ex_op_b = rt_data_q;
        case (sel_b)
            FWD_MEM: ex_op_b = mem_alu_out;
            FWD_WB:  ex_op_b = wb_data;
            default: ex_op_b = rt_data_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush || load_bubble) begin
            ex_rs_q <= '0;
            ex_rt_q <= '0;
        end else if (!stall) begin
            ex_rs_q <= id_rs;
            ex_rt_q <= id_rt;
        end
    end
`else
    logic unused_fwd_data;

    // Without bypassing, ID must wait until every older producer has written
    // the register file (WB writes in the first half of the cycle is not assumed).
    assign hazard = id_depends(ex_rd, ex_valid && (ctrl_q.reg_write || ctrl_q.mem_read))
                 || id_depends(mem_rd, mem_reg_write)
                 || id_depends(wb_rd, wb_reg_write);

    assign ex_op_a = rs_data_q;
    assign ex_op_b = rt_data_q;
    assign unused_fwd_data = ^{mem_alu_out, wb_data};
`endif

    // Priority: reset, flush, stall (hold), load-use bubble, capture.
    always_ff @(posedge clk) begin
        if (rst || flush || load_bubble) begin
            ex_valid  <= 1'b0;
            ex_pc     <= '0;
            ex_imm    <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            ex_rd     <= '0;
            alu_op_q  <= '0;
            ctrl_q    <= CTRL_BUBBLE;
        end else if (!stall) begin
            ex_valid  <= id_valid;
            ex_pc     <= id_pc;
            ex_imm    <= id_imm;
            rs_data_q <= id_rs_data;
            rt_data_q <= id_rt_data;
            ex_rd     <= id_rd;
            alu_op_q  <= id_alu_op;
            ctrl_q    <= id_ctrl;
        end
    end

    assign ex_alu_op     = alu_op_q;
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed test of id_ex_stage. Expected values are
// hand-computed; forwarding-dependent expectations follow ID_EX_FWD_EN.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid;
    logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [3:0]  id_alu_op;
    logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_reg_write, wb_reg_write;
    logic [31:0] mem_alu_out, wb_data;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_imm, ex_op_a, ex_op_b;
    logic [4:0]  ex_rd;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic        load_use_stall;

    int checks = 0;
    int errors = 0;

    // clock / reset block
    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_op(id_alu_op),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_alu_out(mem_alu_out),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_op_a(ex_op_a),
        .ex_op_b(ex_op_b), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .load_use_stall(load_use_stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        id_valid = 0; id_pc = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_alu_op = 0; id_alu_src = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    endtask

    task automatic clear_fwd();
        mem_rd = 0; mem_reg_write = 0; mem_alu_out = 0;
        wb_rd = 0; wb_reg_write = 0; wb_data = 0;
    endtask

    task automatic drive_instr(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic is_load);
        id_valid = 1; id_pc = pc; id_rs_data = a; id_rt_data = b; id_imm = 0;
        id_rs = rs; id_rt = rt; id_rd = rd; id_alu_op = 4'd1; id_alu_src = 0;
        id_reg_write = 1; id_mem_read = is_load; id_mem_write = 0; id_mem_to_reg = is_load;
    endtask

    function automatic logic [4:0] ctrl_bits();
        return {ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg};
    endfunction

    initial begin
        rst = 1; stall = 0; flush = 0;
        clear_fwd();
        // garbage on ID during reset
        id_valid = 1; id_pc = 32'hDEAD_BEEF; id_rs_data = 32'h1357; id_rt_data = 32'h2468;
        id_imm = 32'hFFFF; id_rs = 5; id_rt = 6; id_rd = 5; id_alu_op = 4'hF; id_alu_src = 1;
        id_reg_write = 1; id_mem_read = 1; id_mem_write = 1; id_mem_to_reg = 1;
        tick(); tick();
        check("rst_valid", 32'(ex_valid), 0);
        check("rst_pc", ex_pc, 0);
        check("rst_imm", ex_imm, 0);
        check("rst_op_a", ex_op_a, 0);
        check("rst_op_b", ex_op_b, 0);
        check("rst_rd", 32'(ex_rd), 0);
        check("rst_alu_op", 32'(ex_alu_op), 0);
        check("rst_ctrl", 32'(ctrl_bits()), 0);
        check("rst_lus", 32'(load_use_stall), 0);

        // plain capture
        rst = 0;
        clear_id();
        drive_instr(32'h40, 32'h11, 32'h22, 5'd1, 5'd2, 5'd4, 1'b0);
        id_imm = 32'h7; id_alu_op = 4'd3; id_alu_src = 1;
        tick();
        id_valid = 0;
        check("cap_valid", 32'(ex_valid), 1);
        check("cap_pc", ex_pc, 32'h40);
        check("cap_op_a", ex_op_a, 32'h11);
        check("cap_op_b", ex_op_b, 32'h22);
        check("cap_imm", ex_imm, 32'h7);
        check("cap_rd", 32'(ex_rd), 4);
        check("cap_alu_op", 32'(ex_alu_op), 3);
        check("cap_ctrl", 32'(ctrl_bits()), 32'b11000);

        // forwarding priority: EX holds rs=3, rt=6
        drive_instr(32'h44, 32'h1234, 32'h5678, 5'd3, 5'd6, 5'd7, 1'b0);
        tick();
        clear_id();
        mem_rd = 3; mem_reg_write = 1; mem_alu_out = 32'hAAAA;
        wb_rd = 3; wb_reg_write = 1; wb_data = 32'hBBBB;
        #1;
`ifdef ID_EX_FWD_EN
        check("fwd_mem_prio", ex_op_a, 32'hAAAA);
`else
        check("fwd_mem_prio", ex_op_a, 32'h1234);
`endif
        check("fwd_b_untouched", ex_op_b, 32'h5678);
        mem_reg_write = 0; #1;
`ifdef ID_EX_FWD_EN
        check("fwd_wb", ex_op_a, 32'hBBBB);
`else
        check("fwd_wb", ex_op_a, 32'h1234);
`endif
        mem_reg_write = 1; mem_rd = 0; wb_rd = 0; #1;
        check("fwd_r0", ex_op_a, 32'h1234);
        wb_rd = 6; #1;
`ifdef ID_EX_FWD_EN
        check("fwd_wb_b", ex_op_b, 32'hBBBB);
`else
        check("fwd_wb_b", ex_op_b, 32'h5678);
`endif
        // an ID reader of a MEM/WB producer only stalls without forwarding
        id_valid = 1; id_rs = 3; mem_rd = 3; wb_rd = 0; #1;
`ifdef ID_EX_FWD_EN
        check("mem_dep_lus", 32'(load_use_stall), 0);
`else
        check("mem_dep_lus", 32'(load_use_stall), 1);
`endif
        mem_reg_write = 0; wb_rd = 3; id_rs = 0; id_rt = 3; #1;
`ifdef ID_EX_FWD_EN
        check("wb_dep_lus", 32'(load_use_stall), 0);
`else
        check("wb_dep_lus", 32'(load_use_stall), 1);
`endif
        clear_id(); clear_fwd();
        tick();

        // load-use: load r5 in EX, dependent reads r5 in ID
        drive_instr(32'h48, 32'h100, 32'h0, 5'd1, 5'd2, 5'd5, 1'b1);
        tick();
        drive_instr(32'h50, 32'h99, 32'h88, 5'd5, 5'd8, 5'd9, 1'b0);
        #1;
        check("lu_stall", 32'(load_use_stall), 1);
        tick();
        check("lu_bubble_valid", 32'(ex_valid), 0);
        check("lu_bubble_ctrl", 32'(ctrl_bits()), 0);
        check("lu_bubble_pc", ex_pc, 0);
        mem_rd = 5; mem_reg_write = 1; mem_alu_out = 32'h1000; #1;
`ifdef ID_EX_FWD_EN
        check("lu_n1_lus", 32'(load_use_stall), 0);
        tick();
        clear_fwd();
        wb_rd = 5; wb_reg_write = 1; wb_data = 32'hCAFE; #1;
        check("lu_dep_valid", 32'(ex_valid), 1);
        check("lu_dep_pc", ex_pc, 32'h50);
        check("lu_dep_op_a", ex_op_a, 32'hCAFE);
        check("lu_dep_op_b", ex_op_b, 32'h88);
`else
        check("lu_n1_lus", 32'(load_use_stall), 1);
        tick();
        clear_fwd();
        wb_rd = 5; wb_reg_write = 1; wb_data = 32'hCAFE; #1;
        check("lu_n2_valid", 32'(ex_valid), 0);
        check("lu_n2_lus", 32'(load_use_stall), 1);
        tick();
        clear_fwd();
        id_rs_data = 32'hCAFE; #1;
        check("lu_n3_lus", 32'(load_use_stall), 0);
        tick();
        check("lu_dep_valid", 32'(ex_valid), 1);
        check("lu_dep_pc", ex_pc, 32'h50);
        check("lu_dep_op_a", ex_op_a, 32'hCAFE);
        check("lu_dep_op_b", ex_op_b, 32'h88);
`endif
        clear_id(); clear_fwd();
        tick();

        // flush during a load-use condition
        drive_instr(32'h54, 32'h1, 32'h2, 5'd1, 5'd2, 5'd5, 1'b1);
        tick();
        drive_instr(32'h58, 32'h3, 32'h4, 5'd5, 5'd2, 5'd9, 1'b0);
        flush = 1; #1;
        check("flush_lus", 32'(load_use_stall), 0);
        tick();
        flush = 0;
        clear_id();
        check("flush_valid", 32'(ex_valid), 0);
        check("flush_reg_write", 32'(ex_reg_write), 0);
        check("flush_mem_read", 32'(ex_mem_read), 0);
        tick();
        check("flush_single", 32'(ex_valid), 0);

        // stall hold for three cycles while ID changes
        drive_instr(32'h60, 32'h31, 32'h32, 5'd11, 5'd12, 5'd10, 1'b0);
        tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive_instr(32'h70 + 32'(i), 32'h41 + 32'(i), 32'h42, 5'd13, 5'd14, 5'd15, 1'b0);
            tick();
            check("stall_pc", ex_pc, 32'h60);
            check("stall_op_a", ex_op_a, 32'h31);
        end
        stall = 0;
        tick();
        check("release_pc", ex_pc, 32'h72);
        check("release_op_a", ex_op_a, 32'h43);
        check("release_rd", 32'(ex_rd), 15);

        // stall together with load-use: hold, then bubble after release
        drive_instr(32'h80, 32'h0, 32'h0, 5'd1, 5'd2, 5'd6, 1'b1);
        tick();
        drive_instr(32'h84, 32'h0, 32'h0, 5'd6, 5'd2, 5'd9, 1'b0);
        stall = 1;
        tick();
        check("stall_lu_hold_pc", ex_pc, 32'h80);
        check("stall_lu_hold_rd", 32'(ex_mem_read), 1);
        check("stall_lu_lus", 32'(load_use_stall), 1);
        stall = 0;
        tick();
        check("stall_lu_bubble", 32'(ex_valid), 0);

        // reset mid-hazard leaves nothing behind
        drive_instr(32'h90, 32'h5, 32'h6, 5'd1, 5'd2, 5'd5, 1'b1);
        tick();
        drive_instr(32'h94, 32'h7, 32'h8, 5'd5, 5'd2, 5'd9, 1'b0);
        rst = 1;
        tick();
        rst = 0;
        check("rst2_valid", 32'(ex_valid), 0);
        check("rst2_pc", ex_pc, 0);
        check("rst2_ctrl", 32'(ctrl_bits()), 0);
        check("rst2_lus", 32'(load_use_stall), 0);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
